tcm_port_arb: RTL and testbench
===============================

Name: tcm_port_arb

Overview:
- Shares one port of the dual-port TCM RAM between two requesters: requester 0 (instruction fetch) and requester 1 (load/store unit).
- One access is granted per cycle. Arbitration is round-robin, with an optional lock that lets a requester hold the port for a burst.
- The TCM port has a 1-cycle synchronous read (read-first). The block returns read data and a range-error flag to the granted requester on the following cycle.

Parameters:
- ADDR_W, 14, width of the word address driven to the TCM port.
- RANGE_LIMIT, 128, addresses >= this value are out of range (the TCM returns 0 and ignores writes for them).
- LOCK_MAX, 8, maximum consecutive grants a locked requester may hold before it is forced to release.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req0_valid_i  in  1  requester 0 access request.
- req0_addr_i  in  ADDR_W  requester 0 word address.
- req0_data_i  in  32  requester 0 write data.
- req0_wr_i  in  4  requester 0 byte write enables; 0 = read.
- req0_lock_i  in  1  requester 0 wants to keep the grant next cycle.
- req0_accept_o  out  1  requester 0 request taken this cycle.
- resp0_valid_o  out  1  requester 0 response valid.
- resp0_data_o  out  32  requester 0 read data.
- resp0_err_o  out  1  requester 0 out-of-range access.
- req1_* / resp1_*  (same set, same widths)  requester 1 equivalents.
- ram_addr_o  out  ADDR_W  TCM port address.
- ram_data_o  out  32  TCM port write data.
- ram_wr_o  out  4  TCM port byte write enables.
- ram_data_i  in  32  TCM port read data (registered in the RAM).
- grant_cnt0_o, grant_cnt1_o  out  16  saturating grant counters per requester.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - accept, resp valid/err and ram_wr_o are 0; ram_addr_o and ram_data_o are 0.
  - rr_ptr = 0 (requester 0 favoured first); lock state = UNLOCKED; lock count = 0; grant counters = 0.
  - Reset mid-access drops any pending response; no resp_valid follows.
- Grant selection is combinational in cycle N:
  - Only one requester valid: that requester wins.
  - Both valid: the winner is the requester indicated by rr_ptr, unless in LOCKED(k), where k wins if valid.
- Grant actions:
  - The winner's accept_o = 1, and its addr/data/wr are muxed onto ram_*_o in the same cycle.
  - The loser's accept_o = 0; it must hold its request stable.
  - No valid request: ram_wr_o = 0 and ram_addr_o holds its last value.
- rr_ptr update: after a grant to k, rr_ptr <= ~k (the other requester is favoured next). It does not change on idle cycles.
- Lock FSM:
  - UNLOCKED -> LOCKED(k) when k is granted with reqk_lock_i = 1; lock count <= 1.
  - LOCKED(k) -> LOCKED(k) on each further grant to k with lock_i = 1 and lock count < LOCK_MAX; lock count increments.
  - LOCKED(k) -> UNLOCKED when k is granted with lock_i = 0, when k is not valid, or when lock count reaches LOCK_MAX. At LOCK_MAX, rr_ptr forces the other requester next.
  - The other requester is stalled while LOCKED(k) unless k is idle.
- Response latency is exactly 1 cycle:
  - The cycle after a grant to k: respk_valid_o = 1 and respk_data_o = ram_data_i.
  - The returned data is the pre-write contents for write accesses (read-first).
  - respk_err_o = 1 if the registered address was >= RANGE_LIMIT; data is then 0 as returned by the RAM.
  - Responses cannot be back-pressured.
- Response hold: resp data holds its value when valid = 0; err is 0 when valid = 0.
- Grant counters: gnt_cnt increments on each accept and saturates at 16'hFFFF.
- Simultaneous events:
  - A request and a response for the same requester in the same cycle are legal (back-to-back accesses, full throughput).
  - A change of lock_i on a non-granted cycle is ignored.

Decomposition:
- Shared package tcm_pkg holds:
  - TCM_ADDR_W = 14 and TCM_RANGE_LIMIT = 128.
  - Typedef tcm_req_t {valid, addr, data, wr, lock}.
  - Typedef tcm_resp_t {valid, data, err}.
  - Lock-state enum {UNLOCKED, LOCKED0, LOCKED1}.
- Natural sub-module: tcm_rr_arb2, a 2-way round-robin picker with lock override and lock counter. tcm_port_arb instantiates it plus the port mux, the response tag register and the grant counters.

Test Plan:
- Single requester: req0 reads addr 5 for 3 back-to-back cycles -> accept0 = 1 every cycle; resp0_valid 1 cycle later each time with RAM word 5; req1 has no accepts.
- Contention: both valid continuously, no lock -> grants alternate 0,1,0,1 starting with 0 after reset; grant_cnt0 = grant_cnt1 = 4 after 8 cycles.
- Lock burst: req1 lock = 1 for 12 cycles with req0 valid -> req1 granted 8 consecutive cycles (LOCK_MAX), then req0 granted once, then req1 relocks.
- Write then read: req0 writes 0xDEADBEEF with wr = 4'b0011 to addr 3 (old value 0), then reads addr 3 -> first resp data 0, second 0x0000BEEF.
- Out of range: req1 reads addr 200 -> resp1_valid = 1, resp1_err = 1, data 0; a write to addr 200 leaves the RAM unchanged.
- Reset mid-access: assert rst_i asynchronously between the grant and the response cycle -> resp valid stays 0, rr_ptr = 0, counters are 0 and the FSM is UNLOCKED after release.

Source files
------------

// File: rtl/tcm_pkg.sv
// Shared types and defaults for the TCM port arbiter: request/response records
// and the lock-state encoding.
package tcm_pkg;

    localparam int TCM_ADDR_W      = 14;
    localparam int TCM_RANGE_LIMIT = 128;

    typedef struct packed {
        logic                  valid;
        logic [TCM_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic [3:0]            wr;
        logic                  lock;
    } tcm_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        err;
    } tcm_resp_t;

    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_e;

endpackage

// File: rtl/tcm_rr_arb2.sv
// Two-way round-robin picker. A granted requester asserting lock keeps the port
// for up to LOCK_MAX consecutive grants, after which the other side is favoured.
module tcm_rr_arb2
    import tcm_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    lock_state_e   state;
    logic          rr_ptr;
    logic [CW-1:0] lock_cnt;
    logic          pick;
    logic          win;
    logic          held;

    assign win  = gnt[1];
    assign held = (state == LOCKED1);

    always_comb begin
        pick = rr_ptr;
        if (state == LOCKED0)      pick = 1'b0;
        else if (state == LOCKED1) pick = 1'b1;
        gnt = 2'b00;
        // Reset blocks grants immediately, not just at the next edge.
        if (!rst_i) begin
            if (valid[0] && (!valid[1] || !pick)) gnt[0] = 1'b1;
            else if (valid[1])                    gnt[1] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= UNLOCKED;
            rr_ptr   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            if (|gnt) rr_ptr <= ~win;
            case (state)
                UNLOCKED: begin
                    if ((|gnt) && lock[win] && LOCK_MAX > 1) begin
                        state    <= win ? LOCKED1 : LOCKED0;
                        lock_cnt <= CW'(1);
                    end
                end
                default: begin
                    // Release on the grant that would make the burst LOCK_MAX long.
                    if (gnt[held] && lock[held] && lock_cnt < CW'(LOCK_MAX - 1)) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end else begin
                        state    <= UNLOCKED;
                        lock_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/tcm_port_arb.sv
// Shares one TCM RAM port between instruction fetch (0) and load/store (1):
// grant mux, one-cycle response return with range error, and grant counters.
module tcm_port_arb
    import tcm_pkg::*;
#(
    parameter int ADDR_W      = TCM_ADDR_W,
    parameter int RANGE_LIMIT = TCM_RANGE_LIMIT,
    parameter int LOCK_MAX    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [31:0]       req0_data_i,
    input  logic [3:0]        req0_wr_i,
    input  logic              req0_lock_i,
    output logic              req0_accept_o,
    output logic              resp0_valid_o,
    output logic [31:0]       resp0_data_o,
    output logic              resp0_err_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [31:0]       req1_data_i,
    input  logic [3:0]        req1_wr_i,
    input  logic              req1_lock_i,
    output logic              req1_accept_o,
    output logic              resp1_valid_o,
    output logic [31:0]       resp1_data_o,
    output logic              resp1_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    output logic [3:0]        ram_wr_o,
    input  logic [31:0]       ram_data_i,
    output logic [15:0]       grant_cnt0_o,
    output logic [15:0]       grant_cnt1_o
);

    tcm_req_t  [1:0]       req;
    tcm_resp_t [1:0]       resp;
    logic      [1:0]       gnt;
    logic      [1:0][15:0] gnt_cnt;
    tcm_req_t              win_req;
    logic                  any_gnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           wdata_q;

    assign req[0] = '{valid: req0_valid_i, addr: req0_addr_i, data: req0_data_i,
                      wr: req0_wr_i, lock: req0_lock_i};
    assign req[1] = '{valid: req1_valid_i, addr: req1_addr_i, data: req1_data_i,
                      wr: req1_wr_i, lock: req1_lock_i};

    tcm_rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .valid ({req[1].valid, req[0].valid}),
        .lock  ({req[1].lock,  req[0].lock}),
        .gnt   (gnt)
    );

    assign any_gnt = |gnt;
    assign win_req = gnt[1] ? req[1] : req[0];

    // Idle cycles keep the last address/data on the port, with writes disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_gnt) begin
            addr_q  <= win_req.addr;
            wdata_q <= win_req.data;
        end
    end

    assign ram_addr_o = any_gnt ? win_req.addr : addr_q;
    assign ram_data_o = any_gnt ? win_req.data : wdata_q;
    assign ram_wr_o   = any_gnt ? win_req.wr   : 4'b0000;

    for (genvar i = 0; i < 2; i++) begin : g_req
        logic        vld_q;
        logic        err_q;
        logic [31:0] hold_q;
        logic [15:0] cnt_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q  <= 1'b0;
                err_q  <= 1'b0;
                hold_q <= '0;
                cnt_q  <= '0;
            end else begin
                vld_q <= gnt[i];
                err_q <= gnt[i] && (32'(req[i].addr) >= 32'(RANGE_LIMIT));
                if (vld_q) hold_q <= ram_data_i;
                if (gnt[i] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
        end

        assign resp[i]    = '{valid: vld_q, data: vld_q ? ram_data_i : hold_q,
                              err: vld_q & err_q};
        assign gnt_cnt[i] = cnt_q;
    end

    assign req0_accept_o = gnt[0];
    assign req1_accept_o = gnt[1];
    assign resp0_valid_o = resp[0].valid;
    assign resp0_data_o  = resp[0].data;
    assign resp0_err_o   = resp[0].err;
    assign resp1_valid_o = resp[1].valid;
    assign resp1_data_o  = resp[1].data;
    assign resp1_err_o   = resp[1].err;
    assign grant_cnt0_o  = gnt_cnt[0];
    assign grant_cnt1_o  = gnt_cnt[1];

endmodule

// File: tb/tb_tcm_port_arb.sv
// Bench for tcm_port_arb: behavioural read-first TCM, shadow memory feeding a
// response scoreboard, a vector table and hand-written lock/reset sequences.
module tb_tcm_port_arb;

    typedef struct packed {
        logic        v;
        logic [13:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        logic        l;
    } rq_t;

    typedef struct packed {
        rq_t        r0;
        rq_t        r1;
        logic [1:0] eg;
    } vec_t;

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req0_valid_i, req0_wr_lock_dummy;
    logic [13:0] req0_addr_i;
    logic [31:0] req0_data_i;
    logic [3:0]  req0_wr_i;
    logic        req0_lock_i, req0_accept_o, resp0_valid_o, resp0_err_o;
    logic [31:0] resp0_data_o;
    logic        req1_valid_i;
    logic [13:0] req1_addr_i;
    logic [31:0] req1_data_i;
    logic [3:0]  req1_wr_i;
    logic        req1_lock_i, req1_accept_o, resp1_valid_o, resp1_err_o;
    logic [31:0] resp1_data_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [3:0]  ram_wr_o;
    logic [31:0] ram_rd;
    logic [15:0] grant_cnt0_o, grant_cnt1_o;

    logic        ram_init;
    logic [31:0] mem    [0:127];
    logic [31:0] sh_mem [0:127];
    exp_t        exp_q [$];
    int          exp_cnt [2];
    int          n_cmp = 0;
    int          n_mis = 0;
    vec_t        tbl [13];

    always #5 clk_i = ~clk_i;

    tcm_port_arb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_wr_i(req0_wr_i), .req0_lock_i(req0_lock_i), .req0_accept_o(req0_accept_o),
        .resp0_valid_o(resp0_valid_o), .resp0_data_o(resp0_data_o), .resp0_err_o(resp0_err_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_wr_i(req1_wr_i), .req1_lock_i(req1_lock_i), .req1_accept_o(req1_accept_o),
        .resp1_valid_o(resp1_valid_o), .resp1_data_o(resp1_data_o), .resp1_err_o(resp1_err_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_wr_o(ram_wr_o),
        .ram_data_i(ram_rd), .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o)
    );

    function automatic logic [31:0] init_word(input int a);
        return (a == 3) ? 32'h0 : {16'hC0DE, 16'(a)};
    endfunction

    // Read-first synchronous TCM; out-of-range reads return 0, writes are dropped.
    always @(posedge clk_i) begin
        if (ram_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            ram_rd <= 32'h0;
        end else if (ram_addr_o < 14'd128) begin
            ram_rd <= mem[ram_addr_o[6:0]];
            for (int b = 0; b < 4; b++)
                if (ram_wr_o[b]) mem[ram_addr_o[6:0]][8*b +: 8] <= ram_data_o[8*b +: 8];
        end else begin
            ram_rd <= 32'h0;
        end
    end

    function automatic rq_t rq(input logic v, input logic [13:0] a, input logic [31:0] d,
                               input logic [3:0] w, input logic l);
        rq_t r;
        r.v = v; r.a = a; r.d = d; r.w = w; r.l = l;
        return r;
    endfunction
    function automatic rq_t rd(input logic [13:0] a);  return rq(1'b1, a, 32'h0, 4'h0, 1'b0); endfunction
    function automatic rq_t rdl(input logic [13:0] a); return rq(1'b1, a, 32'h0, 4'h0, 1'b1); endfunction
    function automatic rq_t wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] w);
        return rq(1'b1, a, d, w, 1'b0);
    endfunction
    function automatic rq_t idle(); return rq(1'b0, 14'h0, 32'h0, 4'h0, 1'b0); endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input rq_t r0, input rq_t r1);
        req0_valid_i = r0.v; req0_addr_i = r0.a; req0_data_i = r0.d; req0_wr_i = r0.w; req0_lock_i = r0.l;
        req1_valid_i = r1.v; req1_addr_i = r1.a; req1_data_i = r1.d; req1_wr_i = r1.w; req1_lock_i = r1.l;
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.who) begin
                chk({tag, " r1 vld"}, 32'(resp1_valid_o), 32'd1);
                chk({tag, " r0 vld"}, 32'(resp0_valid_o), 32'd0);
                chk({tag, " r1 data"}, resp1_data_o, e.data);
                chk({tag, " r1 err"}, 32'(resp1_err_o), 32'(e.err));
            end else begin
                chk({tag, " r0 vld"}, 32'(resp0_valid_o), 32'd1);
                chk({tag, " r1 vld"}, 32'(resp1_valid_o), 32'd0);
                chk({tag, " r0 data"}, resp0_data_o, e.data);
                chk({tag, " r0 err"}, 32'(resp0_err_o), 32'(e.err));
            end
        end else begin
            chk({tag, " idle vld"}, 32'({resp1_valid_o, resp0_valid_o}), 32'd0);
            chk({tag, " idle err"}, 32'({resp1_err_o, resp0_err_o}), 32'd0);
        end
        chk({tag, " cnt0"}, 32'(grant_cnt0_o), 32'(exp_cnt[0]));
        chk({tag, " cnt1"}, 32'(grant_cnt1_o), 32'(exp_cnt[1]));
    endtask

    // One cycle: called at posedge+1, checks the grant at negedge, response after the edge.
    task automatic cyc(input rq_t r0, input rq_t r1, input logic [1:0] eg, input string tag);
        rq_t  w;
        exp_t e;
        drive(r0, r1);
        @(negedge clk_i);
        chk({tag, " accept"}, 32'({req1_accept_o, req0_accept_o}), 32'(eg));
        if (eg != 2'b00) begin
            w = eg[1] ? r1 : r0;
            chk({tag, " ram_addr"}, 32'(ram_addr_o), 32'(w.a));
            chk({tag, " ram_wr"}, 32'(ram_wr_o), 32'(w.w));
            chk({tag, " ram_data"}, ram_data_o, w.d);
            e.who  = eg[1];
            e.err  = (w.a >= 14'd128);
            e.data = e.err ? 32'h0 : sh_mem[w.a[6:0]];
            exp_q.push_back(e);
            if (!e.err)
                for (int b = 0; b < 4; b++)
                    if (w.w[b]) sh_mem[w.a[6:0]][8*b +: 8] = w.d[8*b +: 8];
            exp_cnt[eg[1]]++;
        end else begin
            chk({tag, " ram_wr idle"}, 32'(ram_wr_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        check_resp(tag);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(idle(), idle());
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst accept", 32'({req1_accept_o, req0_accept_o}), 32'd0);
        chk("rst resp", 32'({resp1_valid_o, resp0_valid_o, resp1_err_o, resp0_err_o}), 32'd0);
        chk("rst ram_wr", 32'(ram_wr_o), 32'd0);
        chk("rst ram_addr", 32'(ram_addr_o), 32'd0);
        chk("rst ram_data", ram_data_o, 32'd0);
        chk("rst cnts", {grant_cnt1_o, grant_cnt0_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        exp_q.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) sh_mem[i] = init_word(i);
        tbl[0]  = '{rd(14'd1),  idle(),     2'b01};
        tbl[1]  = '{rd(14'd2),  rd(14'd130), 2'b10};
        tbl[2]  = '{idle(),     rd(14'd4),  2'b10};
        tbl[3]  = '{wr(14'd6, 32'h12345678, 4'b1100), rd(14'd7), 2'b01};
        tbl[4]  = '{idle(),     idle(),     2'b00};
        tbl[5]  = '{rdl(14'd8), rd(14'd9),  2'b10};
        tbl[6]  = '{rdl(14'd8), rd(14'd9),  2'b01};
        tbl[7]  = '{rdl(14'd11), rd(14'd9), 2'b01};
        tbl[8]  = '{rd(14'd6),  rd(14'd9),  2'b01};
        tbl[9]  = '{rd(14'd12), rd(14'd9),  2'b10};
        tbl[10] = '{rdl(14'd13), rd(14'd9), 2'b01};
        tbl[11] = '{idle(),     rd(14'd14), 2'b10};
        tbl[12] = '{rd(14'd15), rd(14'd16), 2'b01};

        ram_init = 1'b1;
        drive(idle(), idle());
        @(posedge clk_i);
        #1 ram_init = 1'b0;
        do_reset();

        for (int i = 0; i < 3; i++) cyc(rd(14'd5), idle(), 2'b01, "single");
        chk("single word5", resp0_data_o, 32'hC0DE0005);

        cyc(wr(14'd3, 32'hDEADBEEF, 4'b0011), idle(), 2'b01, "wr3");
        chk("wr3 old data", resp0_data_o, 32'h0);
        cyc(rd(14'd3), idle(), 2'b01, "rd3");
        chk("rd3 data", resp0_data_o, 32'h0000BEEF);
        cyc(idle(), idle(), 2'b00, "hold");
        chk("hold data", resp0_data_o, 32'h0000BEEF);

        cyc(idle(), rd(14'd200), 2'b10, "oor rd");
        chk("oor rd err", 32'(resp1_err_o), 32'd1);
        chk("oor rd data", resp1_data_o, 32'h0);
        cyc(idle(), wr(14'd200, 32'hFFFFFFFF, 4'hF), 2'b10, "oor wr");
        cyc(idle(), rd(14'd72), 2'b10, "oor alias");
        chk("oor alias data", resp1_data_o, 32'hC0DE0048);
        cyc(rd(14'd1), idle(), 2'b01, "rr to 1");

        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(rd(14'd10), rd(14'd20), (i % 2 == 1) ? 2'b10 : 2'b01, "contend");
        chk("contend cnt0", 32'(grant_cnt0_o), 32'd4);
        chk("contend cnt1", 32'(grant_cnt1_o), 32'd4);

        for (int i = 0; i < 13; i++)
            cyc(tbl[i].r0, tbl[i].r1, tbl[i].eg, $sformatf("vec%0d", i));

        do_reset();
        cyc(rd(14'd1), idle(), 2'b01, "burst pre");
        for (int c = 0; c < 12; c++)
            cyc(rd(14'd2), rdl(14'd30), (c == 8) ? 2'b01 : 2'b10, $sformatf("burst%0d", c));
        chk("burst cnt0", 32'(grant_cnt0_o), 32'd2);
        chk("burst cnt1", 32'(grant_cnt1_o), 32'd11);

        // Reset during the response cycle of a locked access.
        cyc(idle(), rdl(14'd40), 2'b10, "lk");
        drive(idle(), rdl(14'd41));
        @(negedge clk_i);
        chk("mid accept1", 32'(req1_accept_o), 32'd1);
        @(posedge clk_i);
        #1;
        chk("mid resp1 before rst", 32'(resp1_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mid resp1 dropped", 32'(resp1_valid_o), 32'd0);
        chk("mid accept1 in rst", 32'(req1_accept_o), 32'd0);
        chk("mid cnts", {grant_cnt1_o, grant_cnt0_o}, 32'd0);
        drive(idle(), idle());
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(posedge clk_i);
        #1;
        chk("post rst no resp", 32'({resp1_valid_o, resp0_valid_o}), 32'd0);
        cyc(rd(14'd5), rd(14'd6), 2'b01, "post rst unlocked");

        // Reset asserted between the grant and its capturing edge.
        drive(rd(14'd5), idle());
        @(negedge clk_i);
        chk("pre-edge accept0", 32'(req0_accept_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("pre-edge accept0 rst", 32'(req0_accept_o), 32'd0);
        drive(idle(), idle());
        @(posedge clk_i);
        #1;
        chk("pre-edge no resp", 32'(resp0_valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        @(posedge clk_i);
        #1;
        chk("pre-edge still none", 32'(resp0_valid_o), 32'd0);
        chk("pre-edge cnt0", 32'(grant_cnt0_o), 32'd0);
        cyc(rd(14'd7), rd(14'd8), 2'b01, "pre-edge rr0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
